// File: rtl/response_checker_if.sv
// response_checker_if: bundle between the NCL test-harness stimulus side and
// the response checker. The master modport belongs to the stimulus side and
// the slave modport to the checker.
// Optional macro CHK_FIRST_FAIL_EN adds the first-failure capture outputs.
interface response_checker_if #(
    parameter int INPUT_PORTS = 4
);
    logic                   clr;
    logic [INPUT_PORTS-1:0] stm_value;
    logic                   stm_vld;
    logic                   rsb;
    logic                   gate_out;
    logic                   gnt;
    logic                   busy;
    logic [15:0]            vec_cnt;
    logic [15:0]            err_cnt;
    logic                   ovr;
    logic                   done;
    logic                   pass;
`ifdef CHK_FIRST_FAIL_EN
    logic [INPUT_PORTS-1:0] first_fail;
    logic                   first_fail_vld;
`endif

    modport master (
        output clr, stm_value, stm_vld, rsb, gate_out, gnt,
`ifdef CHK_FIRST_FAIL_EN
        input  first_fail, first_fail_vld,
`endif
        input  busy, vec_cnt, err_cnt, ovr, done, pass
    );

    modport slave (
        input  clr, stm_value, stm_vld, rsb, gate_out, gnt,
`ifdef CHK_FIRST_FAIL_EN
        output first_fail, first_fail_vld,
`endif
        output busy, vec_cnt, err_cnt, ovr, done, pass
    );
endinterface

// File: rtl/response_checker.sv
// response_checker: receiving end of the NCL gate test harness. Captures each
// vector driven into the gate under test, waits SETTLE_CYCLES, samples the
// gate output and compares it with a THmn threshold-gate model that has
// hysteresis. Counts vectors, mismatches and overruns, and reports a one-cycle
// done pulse with a pass verdict when the generator signals completion.
// Optional macro CHK_FIRST_FAIL_EN: latch the first failing vector and report
// every mismatch in simulation.
module response_checker #(
    parameter int                     INPUT_PORTS   = 4,
    parameter int                     THRESHOLD     = 3,
    parameter logic [4*INPUT_PORTS-1:0] WEIGHTS     = {4'd1, 4'd1, 4'd2, 4'd3},
    parameter bit                     RESET_PORT    = 1'b1,
    parameter bit                     RESET_SENS    = 1'b0,
    parameter bit                     RESET_VAL     = 1'b0,
    parameter int                     SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    response_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_FINISH
    } state_t;

    localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [15:0] CNT_MAX     = 16'hFFFF;

    state_t                 state_q, state_d;
    logic [INPUT_PORTS-1:0] vec_q, vec_d;
    logic                   exp_q, exp_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [15:0]            vec_cnt_q, vec_cnt_d;
    logic [15:0]            err_cnt_q, err_cnt_d;
    logic                   ovr_q, ovr_d;
    logic                   pass_q, pass_d;
    logic                   gnt_pend_q, gnt_pend_d;
    logic                   gnt_prev_q;
`ifdef CHK_FIRST_FAIL_EN
    logic [INPUT_PORTS-1:0] ff_q, ff_d;
    logic                   ff_vld_q, ff_vld_d;
`endif

    logic [7:0]             wterm [INPUT_PORTS];
    logic [7:0]             wsum;
    logic                   gut_rst_act;
    logic                   exp_next;
    logic                   gnt_evt;
    logic                   mismatch;

    // Per-input weight contribution, zero when the input is low.
    generate
        for (genvar gi = 0; gi < INPUT_PORTS; gi++) begin : g_wterm
            assign wterm[gi] = bus.stm_value[gi] ? {4'd0, WEIGHTS[4*gi+3 -: 4]} : 8'd0;
        end
    endgenerate

    // Weighted sum of the asserted inputs; max 8 x 15 fits in 8 bits.
    always_comb begin
        wsum = 8'd0;
        for (int i = 0; i < INPUT_PORTS; i++) begin
            wsum = wsum + wterm[i];
        end
    end

    // Gate reset as seen by the GUT, after polarity selection.
    assign gut_rst_act = RESET_SENS ? bus.rsb : ~bus.rsb;

    // A held-high gnt must not retrigger completion, so act on its rising edge.
    assign gnt_evt  = bus.gnt & ~gnt_prev_q;
    assign mismatch = (state_q == ST_SAMPLE) && (bus.gate_out != exp_q);

    // Threshold-gate model: set at threshold, clear on all-zero, else hold.
    always_comb begin
        if (RESET_PORT && gut_rst_act) begin
            exp_next = RESET_VAL;
        end else if (int'(wsum) >= THRESHOLD) begin
            exp_next = 1'b1;
        end else if (bus.stm_value == '0) begin
            exp_next = 1'b0;
        end else begin
            exp_next = exp_q;
        end
    end

    // Next-state, counters and flags; clr overrides everything except exp.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        exp_d      = exp_q;
        cnt_d      = cnt_q;
        vec_cnt_d  = vec_cnt_q;
        err_cnt_d  = err_cnt_q;
        ovr_d      = ovr_q;
        pass_d     = pass_q;
        gnt_pend_d = gnt_pend_q;
`ifdef CHK_FIRST_FAIL_EN
        ff_d       = ff_q;
        ff_vld_d   = ff_vld_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.stm_vld) begin
                    // A vector coinciding with gnt is checked first.
                    vec_d   = bus.stm_value;
                    exp_d   = exp_next;
                    cnt_d   = SETTLE_LOAD;
                    state_d = ST_SETTLE;
                    if (gnt_evt) begin
                        gnt_pend_d = 1'b1;
                    end
                end else if (gnt_evt || gnt_pend_q) begin
                    // Counters are final here, so the verdict is ready with done.
                    pass_d  = (err_cnt_q == 16'd0) && (vec_cnt_q != 16'd0) && !ovr_q;
                    state_d = ST_FINISH;
                end
            end
            ST_SETTLE: begin
                if (bus.stm_vld) begin
                    ovr_d = 1'b1;
                end
                if (gnt_evt) begin
                    gnt_pend_d = 1'b1;
                end
                if (cnt_q == 4'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (bus.stm_vld) begin
                    ovr_d = 1'b1;
                end
                if (gnt_evt) begin
                    gnt_pend_d = 1'b1;
                end
                if (vec_cnt_q != CNT_MAX) begin
                    vec_cnt_d = vec_cnt_q + 16'd1;
                end
                if (mismatch) begin
                    if (err_cnt_q != CNT_MAX) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
`ifdef CHK_FIRST_FAIL_EN
                    if (!ff_vld_q) begin
                        ff_d     = vec_q;
                        ff_vld_d = 1'b1;
                    end
`endif
                end
                state_d = ST_IDLE;
            end
            ST_FINISH: begin
                // Vectors arriving here are not checked; the sweep is over.
                gnt_pend_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.clr) begin
            state_d    = ST_IDLE;
            cnt_d      = 4'd0;
            vec_cnt_d  = 16'd0;
            err_cnt_d  = 16'd0;
            ovr_d      = 1'b0;
            pass_d     = 1'b0;
            gnt_pend_d = 1'b0;
`ifdef CHK_FIRST_FAIL_EN
            ff_d       = '0;
            ff_vld_d   = 1'b0;
`endif
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, counters and sticky flags; rst also restores the gate model.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q      <= '0;
            exp_q      <= RESET_VAL;
            cnt_q      <= 4'd0;
            vec_cnt_q  <= 16'd0;
            err_cnt_q  <= 16'd0;
            ovr_q      <= 1'b0;
            pass_q     <= 1'b0;
            gnt_pend_q <= 1'b0;
            gnt_prev_q <= 1'b0;
`ifdef CHK_FIRST_FAIL_EN
            ff_q       <= '0;
            ff_vld_q   <= 1'b0;
`endif
        end else begin
            vec_q      <= vec_d;
            exp_q      <= exp_d;
            cnt_q      <= cnt_d;
            vec_cnt_q  <= vec_cnt_d;
            err_cnt_q  <= err_cnt_d;
            ovr_q      <= ovr_d;
            pass_q     <= pass_d;
            gnt_pend_q <= gnt_pend_d;
            gnt_prev_q <= bus.gnt;
`ifdef CHK_FIRST_FAIL_EN
            ff_q       <= ff_d;
            ff_vld_q   <= ff_vld_d;
`endif
        end
    end

`ifdef CHK_FIRST_FAIL_EN
`ifndef SYNTHESIS
    // Simulation-only log of every mismatch.
    always_ff @(posedge clk) begin
        if (!rst && !bus.clr && mismatch) begin
            $display("%0t response_checker mismatch: vector=%b expected=%b actual=%b",
                     $time, vec_q, exp_q, bus.gate_out);
        end
    end
`endif
    assign bus.first_fail     = ff_q;
    assign bus.first_fail_vld = ff_vld_q;
`endif

    assign bus.busy    = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign bus.done    = (state_q == ST_FINISH);
    assign bus.vec_cnt = vec_cnt_q;
    assign bus.err_cnt = err_cnt_q;
    assign bus.ovr     = ovr_q;
    assign bus.pass    = pass_q;

endmodule

// File: tb/tb_response_checker.sv
// Directed bench for response_checker with default parameters
// (weights: in0=3, in1=2, in2=1, in3=1; threshold 3; settle 2).
module tb_response_checker;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    response_checker_if #(.INPUT_PORTS(4)) bus ();

    response_checker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one vector and wait until its sample has completed (back in IDLE).
    task automatic send_vec(input logic [3:0] v, input logic g);
        @(negedge clk);
        bus.stm_value = v;
        bus.gate_out  = g;
        bus.stm_vld   = 1'b1;
        @(negedge clk);
        bus.stm_vld   = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
    endtask

    // Returns on the negedge right after gnt was sampled, where done is due.
    task automatic pulse_gnt();
        @(negedge clk);
        bus.gnt = 1'b1;
        @(negedge clk);
        bus.gnt = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.vec_cnt !== 16'd0) $display("FAIL reset_vec got=%h exp=0", bus.vec_cnt); else pass_cnt++;
        total_cnt++; if (bus.err_cnt !== 16'd0) $display("FAIL reset_err got=%h exp=0", bus.err_cnt); else pass_cnt++;
        total_cnt++; if ({bus.ovr, bus.done, bus.pass} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {bus.ovr, bus.done, bus.pass}); else pass_cnt++;
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_tracking();
        send_vec(4'b0001, 1'b1);
        send_vec(4'b0010, 1'b1);
        send_vec(4'b0000, 1'b0);
        send_vec(4'b0110, 1'b1);
        total_cnt++; if (bus.vec_cnt !== 16'd4) $display("FAIL track_vec got=%0d exp=4", bus.vec_cnt); else pass_cnt++;
        total_cnt++; if (bus.err_cnt !== 16'd0) $display("FAIL track_err got=%0d exp=0", bus.err_cnt); else pass_cnt++;
        pulse_gnt();
        total_cnt++; if (bus.done !== 1'b1) $display("FAIL track_done got=%b exp=1", bus.done); else pass_cnt++;
        total_cnt++; if (bus.pass !== 1'b1) $display("FAIL track_pass got=%b exp=1", bus.pass); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (bus.done !== 1'b0) $display("FAIL track_done_width got=%b exp=0", bus.done); else pass_cnt++;
        total_cnt++; if (bus.pass !== 1'b1) $display("FAIL track_pass_hold got=%b exp=1", bus.pass); else pass_cnt++;
        $display("test_tracking vec=%0d err=%0d", bus.vec_cnt, bus.err_cnt);
    endtask

    task automatic test_hysteresis();
        // Model output is 1 from the previous test; clr must not change it.
        pulse_clr();
        send_vec(4'b0010, 1'b1);
        total_cnt++; if (bus.err_cnt !== 16'd0) $display("FAIL hyst_hold_after_clr got=%0d exp=0", bus.err_cnt); else pass_cnt++;
        send_vec(4'b0010, 1'b0);
        total_cnt++; if (bus.err_cnt !== 16'd1) $display("FAIL hyst_err got=%0d exp=1", bus.err_cnt); else pass_cnt++;
        total_cnt++; if (bus.vec_cnt !== 16'd2) $display("FAIL hyst_vec got=%0d exp=2", bus.vec_cnt); else pass_cnt++;
        pulse_gnt();
        total_cnt++; if ({bus.done, bus.pass} !== 2'b10) $display("FAIL hyst_verdict got=%b exp=10", {bus.done, bus.pass}); else pass_cnt++;
        $display("test_hysteresis err=%0d pass=%b", bus.err_cnt, bus.pass);
    endtask

    task automatic test_gut_reset();
        pulse_clr();
        bus.rsb = 1'b0;
        send_vec(4'b1111, 1'b1);
        total_cnt++; if (bus.err_cnt !== 16'd1) $display("FAIL gutrst_err got=%0d exp=1", bus.err_cnt); else pass_cnt++;
        send_vec(4'b1111, 1'b0);
        total_cnt++; if (bus.err_cnt !== 16'd1) $display("FAIL gutrst_ok got=%0d exp=1", bus.err_cnt); else pass_cnt++;
        bus.rsb = 1'b1;
        $display("test_gut_reset err=%0d vec=%0d", bus.err_cnt, bus.vec_cnt);
    endtask

    task automatic test_latency();
        pulse_clr();
        // Correct value appears only one cycle before the sample edge.
        @(negedge clk);
        bus.stm_value = 4'b0001; bus.gate_out = 1'b0; bus.stm_vld = 1'b1;
        @(negedge clk);
        bus.stm_vld = 1'b0;
        total_cnt++; if (bus.busy !== 1'b1) $display("FAIL lat_busy got=%b exp=1", bus.busy); else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        bus.gate_out = 1'b1;
        @(negedge clk);
        bus.gate_out = 1'b0;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL lat_idle got=%b exp=0", bus.busy); else pass_cnt++;
        total_cnt++; if ({bus.vec_cnt, bus.err_cnt} !== {16'd1, 16'd0}) $display("FAIL lat_late_ok got=%0d/%0d exp=1/0", bus.vec_cnt, bus.err_cnt); else pass_cnt++;
        // Correct value withdrawn one cycle before the sample edge.
        bus.stm_value = 4'b0001; bus.gate_out = 1'b1; bus.stm_vld = 1'b1;
        @(negedge clk);
        bus.stm_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.gate_out = 1'b0;
        @(negedge clk);
        total_cnt++; if ({bus.vec_cnt, bus.err_cnt} !== {16'd2, 16'd1}) $display("FAIL lat_early_bad got=%0d/%0d exp=2/1", bus.vec_cnt, bus.err_cnt); else pass_cnt++;
        $display("test_latency vec=%0d err=%0d", bus.vec_cnt, bus.err_cnt);
    endtask

    task automatic test_overrun();
        pulse_clr();
        @(negedge clk);
        bus.stm_value = 4'b0001; bus.gate_out = 1'b1; bus.stm_vld = 1'b1;
        @(negedge clk);
        bus.stm_value = 4'b0000;
        @(negedge clk);
        bus.stm_vld = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (bus.ovr !== 1'b1) $display("FAIL ovr_flag got=%b exp=1", bus.ovr); else pass_cnt++;
        total_cnt++; if ({bus.vec_cnt, bus.err_cnt} !== {16'd1, 16'd0}) $display("FAIL ovr_counts got=%0d/%0d exp=1/0", bus.vec_cnt, bus.err_cnt); else pass_cnt++;
        pulse_gnt();
        total_cnt++; if ({bus.done, bus.pass} !== 2'b10) $display("FAIL ovr_verdict got=%b exp=10", {bus.done, bus.pass}); else pass_cnt++;
        $display("test_overrun ovr=%b vec=%0d", bus.ovr, bus.vec_cnt);
    endtask

    task automatic test_gnt_in_settle();
        pulse_clr();
        @(negedge clk);
        bus.stm_value = 4'b0001; bus.gate_out = 1'b1; bus.stm_vld = 1'b1;
        @(negedge clk);
        bus.stm_vld = 1'b0; bus.gnt = 1'b1;
        @(negedge clk);
        bus.gnt = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total_cnt++; if ({bus.busy, bus.done} !== 2'b00) $display("FAIL gset_idle got=%b exp=00", {bus.busy, bus.done}); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (bus.done !== 1'b1) $display("FAIL gset_done got=%b exp=1", bus.done); else pass_cnt++;
        total_cnt++; if ({bus.vec_cnt, bus.pass} !== {16'd1, 1'b1}) $display("FAIL gset_vec_pass got=%0d/%b exp=1/1", bus.vec_cnt, bus.pass); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (bus.done !== 1'b0) $display("FAIL gset_done_width got=%b exp=0", bus.done); else pass_cnt++;
        $display("test_gnt_in_settle vec=%0d pass=%b", bus.vec_cnt, bus.pass);
    endtask

    task automatic test_gnt_coincide();
        pulse_clr();
        @(negedge clk);
        bus.stm_value = 4'b0001; bus.gate_out = 1'b1; bus.stm_vld = 1'b1; bus.gnt = 1'b1;
        @(negedge clk);
        bus.stm_vld = 1'b0; bus.gnt = 1'b0;
        total_cnt++; if ({bus.busy, bus.done} !== 2'b10) $display("FAIL gco_vec_wins got=%b exp=10", {bus.busy, bus.done}); else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++; if ({bus.done, bus.pass, bus.vec_cnt} !== {1'b1, 1'b1, 16'd1}) $display("FAIL gco_done got=%b/%b/%0d exp=1/1/1", bus.done, bus.pass, bus.vec_cnt); else pass_cnt++;
        $display("test_gnt_coincide done=%b", bus.done);
    endtask

    task automatic test_saturation_clear();
        // Stream mismatching vectors back to back; every one is a mismatch.
        @(negedge clk);
        bus.stm_value = 4'b0001; bus.gate_out = 1'b0; bus.stm_vld = 1'b1;
        repeat (4 * 65536 + 8) @(negedge clk);
        bus.stm_vld = 1'b0;
        repeat (6) @(negedge clk);
        total_cnt++; if (bus.err_cnt !== 16'hFFFF) $display("FAIL sat_err got=%h exp=ffff", bus.err_cnt); else pass_cnt++;
        total_cnt++; if (bus.vec_cnt !== 16'hFFFF) $display("FAIL sat_vec got=%h exp=ffff", bus.vec_cnt); else pass_cnt++;
        pulse_clr();
        total_cnt++; if ({bus.vec_cnt, bus.err_cnt} !== 32'd0) $display("FAIL clr_counts got=%h/%h exp=0/0", bus.vec_cnt, bus.err_cnt); else pass_cnt++;
        total_cnt++; if ({bus.ovr, bus.pass, bus.busy} !== 3'b000) $display("FAIL clr_flags got=%b exp=000", {bus.ovr, bus.pass, bus.busy}); else pass_cnt++;
        $display("test_saturation_clear err=%h", bus.err_cnt);
    endtask

    task automatic test_async_reset();
        send_vec(4'b0001, 1'b1);
        @(negedge clk);
        bus.stm_value = 4'b0001; bus.gate_out = 1'b1; bus.stm_vld = 1'b1;
        @(negedge clk);
        bus.stm_vld = 1'b0;
        total_cnt++; if (bus.busy !== 1'b1) $display("FAIL arst_busy_before got=%b exp=1", bus.busy); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++; if ({bus.busy, bus.vec_cnt} !== {1'b0, 16'd0}) $display("FAIL arst_immediate got=%b/%0d exp=0/0", bus.busy, bus.vec_cnt); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        // Model restored to 0 by rst: a sub-threshold vector holds 0.
        send_vec(4'b0010, 1'b0);
        total_cnt++; if ({bus.vec_cnt, bus.err_cnt} !== {16'd1, 16'd0}) $display("FAIL arst_model got=%0d/%0d exp=1/0", bus.vec_cnt, bus.err_cnt); else pass_cnt++;
        $display("test_async_reset vec=%0d err=%0d", bus.vec_cnt, bus.err_cnt);
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        rst           = 1'b1;
        bus.clr       = 1'b0;
        bus.stm_value = 4'b0000;
        bus.stm_vld   = 1'b0;
        bus.rsb       = 1'b1;
        bus.gate_out  = 1'b0;
        bus.gnt       = 1'b0;
        test_reset();
        test_tracking();
        test_hysteresis();
        test_gut_reset();
        test_latency();
        test_overrun();
        test_gnt_in_settle();
        test_gnt_coincide();
        test_saturation_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/response_checker.md
Name: response_checker

Overview:
- Receiving end of the NCL gate test harness: consumes the vectors that stimulus_gen drives into a gate under test (GUT) and samples the GUT output after a settle delay.
- Compares each sample against a built-in NCL threshold-gate model with hysteresis, and counts vectors, mismatches and overruns.
- On the generator's completion grant (gnt), reports a one-cycle done pulse and a pass verdict.

Parameters:
- INPUT_PORTS, 4: GUT input width, 1..8.
- THRESHOLD, 3: gate threshold m of THmn.
- WEIGHTS, {4'd1,4'd1,4'd2,4'd3}: packed 4-bit weight per input; input i uses bits [4i+3:4i].
- RESET_PORT, 1: 0 = GUT has no reset, 1 = GUT has reset.
- RESET_SENS, 0: polarity of rsb; 0 = active-low, 1 = active-high.
- RESET_VAL, 0: GUT output value while the GUT is held in reset.
- SETTLE_CYCLES, 2: clocks between vector capture and output sample, 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of counters and sticky flags.
- stm_value  in  INPUT_PORTS  vector currently applied to the GUT.
- stm_vld  in  1  one-cycle strobe; stm_value is new this cycle.
- rsb  in  1  GUT reset, as driven by stimulus_gen.
- gate_out  in  1  GUT output.
- gnt  in  1  generator sweep complete (level or pulse).
- busy  out  1  checker in SETTLE or SAMPLE.
- vec_cnt  out  16  vectors checked, saturating at 16'hFFFF.
- err_cnt  out  16  mismatches, saturating at 16'hFFFF.
- ovr  out  1  sticky; stm_vld arrived while busy.
- done  out  1  one-cycle completion pulse.
- pass  out  1  verdict, valid from done onward.

Behaviour:
- Reset: state=IDLE, exp=RESET_VAL, all outputs 0, settle counter 0, gnt_pend 0.
- Weighted sum: 8-bit unsigned sum of WEIGHTS[i] for each stm_value[i]==1. It must not overflow: INPUT_PORTS ≤ 8, weights ≤ 15.
- Model update, evaluated at capture:
  - If RESET_PORT=1 and rsb is asserted per RESET_SENS: exp_next = RESET_VAL.
  - Else if sum ≥ THRESHOLD: exp_next = 1.
  - Else if stm_value == 0: exp_next = 0.
  - Else: exp_next = exp (hold / hysteresis).
- FSM:
  - IDLE: on stm_vld, register the vector, compute exp_next, load cnt=SETTLE_CYCLES-1, go to SETTLE.
    - gnt or gnt_pend with no stm_vld: go to FINISH.
    - If stm_vld and gnt coincide, the vector wins and gnt_pend is set.
  - SETTLE: busy=1, cnt decrements; at cnt==0 go to SAMPLE. Total capture-to-sample latency is SETTLE_CYCLES+1 clocks.
  - SAMPLE: busy=1. Compare gate_out with exp, vec_cnt+1; on mismatch err_cnt+1. Return to IDLE.
  - FINISH: done=1 for exactly one cycle. pass = (err_cnt==0) & (vec_cnt!=0) & ~ovr, held until the next done or clr. Clear gnt_pend, return to IDLE.
- stm_vld while busy: the vector is ignored, ovr is set, and the in-flight check is unaffected.
- gnt while busy: set gnt_pend; FINISH follows after SAMPLE→IDLE.
- clr: zeroes vec_cnt, err_cnt, ovr, pass, gnt_pend and aborts to IDLE. It does not change exp; only rst restores exp.
- Counters saturate and do not wrap; err_cnt ≤ vec_cnt always.
- rst mid-operation: immediate return to reset state; any in-flight sample is discarded.

Optional Feature:
CHK_FIRST_FAIL_EN
- Defined: adds outputs first_fail [INPUT_PORTS-1:0] and first_fail_vld (1).
  - On the first mismatch since rst/clr, first_fail latches the failing vector and first_fail_vld is set; later mismatches do not overwrite it.
  - clr and rst zero both outputs.
  - A $display of time, vector, expected and actual is issued on every mismatch (simulation only).
- Undefined: the ports, registers and display are absent; all other behaviour is identical.

Test Plan:
- Defaults, rsb=1, vectors 0001, 0010, 0000, 0110, with gate_out tracking the model as 1,1,0,1 → vec_cnt=4, err_cnt=0; gnt gives done pulse, pass=1.
- Hysteresis: after 0001 (exp 1), apply 0010 with gate_out=0 → err_cnt=1 (sum 2 holds 1); done gives pass=0.
- GUT reset: rsb=0 with vector 1111 and gate_out=1 → mismatch (exp=RESET_VAL=0), err_cnt=1.
- Overrun: second stm_vld one cycle after the first (SETTLE_CYCLES=2) → ovr=1, vec_cnt=1; pass=0 at done.
- gnt in SETTLE: done is asserted exactly one cycle after SAMPLE's return to IDLE; vec_cnt includes that vector.
- Saturation and clear: force 65536 mismatches → err_cnt=16'hFFFF holds. clr → counters 0 and pass=0; async rst mid-SETTLE → busy=0 immediately.
